// File: rtl/alu_datapath.sv
// Arithmetic slice of the execution unit: operand-B select, registered add/subtract ALU
// with carry and zero flags, and the register-file write-data select.
module alu_datapath #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_a,
    input  logic [DATA_BITS-1:0] i_imm,
    input  logic [DATA_BITS-1:0] i_rd1,
    input  logic                 i_b_sel,
    input  logic                 i_subtract,
    input  logic [DATA_BITS-1:0] i_mem_load,
    input  logic [1:0]           i_wd_sel,
    output logic [DATA_BITS-1:0] o_alu_b,
    output logic [DATA_BITS-1:0] o_alu_result,
    output logic                 o_alu_cout,
    output logic                 o_alu_zero,
    output logic [DATA_BITS-1:0] o_wd_out
);

    logic [DATA_BITS-1:0] w_alu_b;
    logic [DATA_BITS-1:0] w_b_eff;
    logic [DATA_BITS:0]   w_sum;
    logic [DATA_BITS-1:0] r_result;
    logic                 r_cout;
    logic                 r_zero;

    assign w_alu_b = i_b_sel ? i_rd1 : i_imm;

    // Subtract is two's complement: invert B and feed subtract in as carry-in,
    // so carry out = 1 means no borrow.
    assign w_b_eff = i_subtract ? ~w_alu_b : w_alu_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_BITS{1'b0}}, i_subtract};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_sum[DATA_BITS-1:0];
            r_cout   <= w_sum[DATA_BITS];
            r_zero   <= (w_sum[DATA_BITS-1:0] == '0);
        end
    end

    always_comb begin
        o_wd_out = r_result;
        case (i_wd_sel)
            2'd0: o_wd_out = r_result;
            2'd1: o_wd_out = i_imm;
            2'd2: o_wd_out = i_mem_load;
            2'd3: o_wd_out = i_a;
        endcase
    end

    assign o_alu_b      = w_alu_b;
    assign o_alu_result = r_result;
    assign o_alu_cout   = r_cout;
    assign o_alu_zero   = r_zero;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath with hand-computed expected values.
module tb_alu_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, imm, rd1, mem_load;
    logic       b_sel, subtract;
    logic [1:0] wd_sel;
    logic [7:0] alu_b, alu_result, wd_out;
    logic       alu_cout, alu_zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_datapath #(.DATA_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_a          (a),
        .i_imm        (imm),
        .i_rd1        (rd1),
        .i_b_sel      (b_sel),
        .i_subtract   (subtract),
        .i_mem_load   (mem_load),
        .i_wd_sel     (wd_sel),
        .o_alu_b      (alu_b),
        .o_alu_result (alu_result),
        .o_alu_cout   (alu_cout),
        .o_alu_zero   (alu_zero),
        .o_wd_out     (wd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_alu(input string tag, input logic [7:0] res, input logic co, input logic z);
        chk({tag, ".result"}, {8'h0, alu_result}, {8'h0, res});
        chk({tag, ".cout"},   {15'h0, alu_cout},  {15'h0, co});
        chk({tag, ".zero"},   {15'h0, alu_zero},  {15'h0, z});
    endtask

    // a, imm, subtract, expected result, expected carry
    logic [7:0] v_a   [6] = '{8'h10, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
    logic [7:0] v_imm [6] = '{8'h20, 8'h80, 8'h80, 8'h01, 8'h00, 8'h02};
    logic       v_sub [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
    logic [7:0] v_res [6] = '{8'h30, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'hFF};
    logic       v_co  [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

    initial begin
        reset = 1'b1; a = 8'h00; imm = 8'h00; rd1 = 8'h00; mem_load = 8'h00;
        b_sel = 1'b0; subtract = 1'b0; wd_sel = 2'd0;
        tick(); tick();
        chk_alu("reset", 8'h00, 1'b0, 1'b1);

        reset = 1'b0;
        a = 8'h05; imm = 8'h03; b_sel = 1'b0; subtract = 1'b0;
        #1 chk("add_imm.alu_b", {8'h0, alu_b}, 16'h0003);
        tick();
        chk_alu("add_imm", 8'h08, 1'b0, 1'b0);
        chk("add_imm.wd0", {8'h0, wd_out}, 16'h0008);

        a = 8'hFF; rd1 = 8'h01; b_sel = 1'b1; subtract = 1'b0;
        tick();
        chk_alu("add_wrap", 8'h00, 1'b1, 1'b1);

        a = 8'h05; imm = 8'h05; b_sel = 1'b0; subtract = 1'b1;
        tick();
        chk_alu("sub_eq", 8'h00, 1'b1, 1'b1);

        a = 8'h03; rd1 = 8'h05; b_sel = 1'b1; subtract = 1'b1;
        tick();
        chk_alu("sub_borrow", 8'hFE, 1'b0, 1'b0);

        imm = 8'h11; mem_load = 8'h22; a = 8'h33; rd1 = 8'h44;
        wd_sel = 2'd1; #1 chk("wd_sel1", {8'h0, wd_out}, 16'h0011);
        wd_sel = 2'd2; #1 chk("wd_sel2", {8'h0, wd_out}, 16'h0022);
        wd_sel = 2'd3; #1 chk("wd_sel3", {8'h0, wd_out}, 16'h0033);
        b_sel = 1'b0;  #1 chk("bsel0",   {8'h0, alu_b},  16'h0011);
        b_sel = 1'b1;  #1 chk("bsel1",   {8'h0, alu_b},  16'h0044);
        wd_sel = 2'd0;

        tick();
        a = 8'h05; imm = 8'h03; b_sel = 1'b0; subtract = 1'b0;
        tick();
        chk_alu("pre_reset", 8'h08, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_alu("mid_reset", 8'h00, 1'b0, 1'b1);
        reset = 1'b0; a = 8'h10; imm = 8'h20;
        #1 chk("hold_after_reset", {8'h0, alu_result}, 16'h0000);
        tick();
        chk_alu("post_reset", 8'h30, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            a = v_a[i]; imm = v_imm[i]; b_sel = 1'b0; subtract = v_sub[i];
            #1;
            if (i > 0) chk($sformatf("b2b%0d.hold", i), {8'h0, alu_result}, {8'h0, v_res[i-1]});
            tick();
            chk_alu($sformatf("b2b%0d", i), v_res[i], v_co[i], v_res[i] == 8'h00);
            chk($sformatf("b2b%0d.wd", i), {8'h0, wd_out}, {8'h0, v_res[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
